eth_tx_sched: RTL and testbench

Round-robin scheduler that shares one `eth_tx` pipe between `REQ_N` application packet sources. It sits between the application requesters and `eth_tx`. For each frame it arbitrates and issues the early-start pulse, then multiplexes the winner's data stream into the pipe. It enforces end-of-frame drain and a minimum inter-frame gap before granting again.

---
 rtl/eth_tx_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/eth_tx_sched.sv | 135 +++++++++++++
 tb/tb_eth_tx_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared defaults and scheduler state encoding for the eth_tx path
package eth_tx_pkg;

    localparam int IFG_N_DEF     = 12;
    localparam int PKT_LEN_W_DEF = 16;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_START = 5'b00010,
        ST_DATA  = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_GAP   = 5'b10000
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr
module rr_arbiter #(
    parameter int REQ_N = 2,
    parameter int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic [REQ_N-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [REQ_N-1:0] grant
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < REQ_N; i++) begin
            // ptr is always below REQ_N, so one subtraction wraps the index
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(REQ_N)) begin
                sum = sum - (PTR_W+1)'(REQ_N);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// rtl/eth_tx_sched.sv - round-robin frame scheduler sharing one eth_tx pipe
module eth_tx_sched import eth_tx_pkg::*; #(
    parameter int REQ_N          = 2,
    parameter int DATA_W         = 16,
    parameter int KEEP_W         = DATA_W/8,
    parameter int LEN_W          = $clog2(KEEP_W+1),
    parameter int PKT_LEN_W      = PKT_LEN_W_DEF,
    parameter int APP_LAST_LEN_W = 4,
    parameter int IFG_N          = IFG_N_DEF,
    parameter int GAP_CYC        = (IFG_N+KEEP_W-1)/KEEP_W
) (
    input  logic                              clk,
    input  logic                              nreset,
    input  logic [REQ_N-1:0]                  req_v_i,
    input  logic [REQ_N*PKT_LEN_W-1:0]        req_pkt_len_i,
    input  logic [REQ_N-1:0]                  req_cancel_i,
    input  logic [REQ_N*DATA_W-1:0]           req_data_i,
    input  logic [REQ_N*LEN_W-1:0]            req_len_i,
    input  logic [REQ_N-1:0]                  req_last_i,
    input  logic [REQ_N-1:0]                  req_last_block_next_i,
    input  logic [REQ_N*APP_LAST_LEN_W-1:0]   req_last_block_next_len_i,
    output logic [REQ_N-1:0]                  grant_o,
    output logic [REQ_N-1:0]                  req_ready_o,
    output logic                              tx_early_v_o,
    output logic [PKT_LEN_W-1:0]              tx_pkt_len_o,
    output logic                              tx_cancel_o,
    input  logic                              tx_ready_v_i,
    output logic [DATA_W-1:0]                 tx_data_o,
    output logic [LEN_W-1:0]                  tx_len_o,
    output logic                              tx_last_o,
    output logic                              tx_last_block_next_o,
    output logic [APP_LAST_LEN_W-1:0]         tx_last_block_next_len_o,
    input  logic                              tx_idle_i
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int GAP_W = $clog2(GAP_CYC+1);

    sched_state_t              state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr, grant_idx, next_ptr;
    logic [REQ_N-1:0]          grant_q, arb_grant;
    logic [PKT_LEN_W-1:0]      pkt_len_q, arb_len;
    logic [GAP_W-1:0]          gap_cnt;
    logic [DATA_W-1:0]         sel_data;
    logic [LEN_W-1:0]          sel_len;
    logic                      sel_last, sel_lbn;
    logic [APP_LAST_LEN_W-1:0] sel_lbn_len;
    logic                      in_frame, in_stream, cancel_hit;

    rr_arbiter #(.REQ_N(REQ_N), .PTR_W(PTR_W)) u_arb (
        .req   (req_v_i),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    always_comb begin
        grant_idx   = '0;
        arb_len     = '0;
        sel_data    = '0;
        sel_len     = '0;
        sel_last    = 1'b0;
        sel_lbn     = 1'b0;
        sel_lbn_len = '0;
        for (int r = 0; r < REQ_N; r++) begin
            if (grant_q[r]) begin
                grant_idx   = PTR_W'(r);
                sel_data    = req_data_i[r*DATA_W +: DATA_W];
                sel_len     = req_len_i[r*LEN_W +: LEN_W];
                sel_last    = req_last_i[r];
                sel_lbn     = req_last_block_next_i[r];
                sel_lbn_len = req_last_block_next_len_i[r*APP_LAST_LEN_W +: APP_LAST_LEN_W];
            end
            if (arb_grant[r]) begin
                arb_len = req_pkt_len_i[r*PKT_LEN_W +: PKT_LEN_W];
            end
        end
    end

    assign next_ptr   = (grant_idx == PTR_W'(REQ_N-1)) ? '0 : grant_idx + 1'b1;
    assign in_frame   = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign in_stream  = (state_q == ST_START) || (state_q == ST_DATA);
    assign cancel_hit = in_frame && |(req_cancel_i & grant_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_v_i) state_d = ST_START;
            ST_START: state_d = cancel_hit ? ST_GAP : ST_DATA;
            ST_DATA: begin
                if (cancel_hit)                    state_d = ST_GAP;
                else if (tx_ready_v_i && sel_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (cancel_hit || tx_idle_i) state_d = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            rr_ptr    <= '0;
            grant_q   <= '0;
            pkt_len_q <= '0;
            gap_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && |req_v_i) begin
                grant_q   <= arb_grant;
                pkt_len_q <= arb_len;
            end
            if (state_d == ST_GAP && state_q != ST_GAP) begin
                gap_cnt <= GAP_W'(GAP_CYC-1);
            end else if (state_q == ST_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            // pointer moves past the owner only once the gap has fully elapsed
            if (state_q == ST_GAP && gap_cnt == '0) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    assign grant_o                  = in_frame ? grant_q : '0;
    assign req_ready_o              = (state_q == ST_DATA) ? (grant_q & {REQ_N{tx_ready_v_i}}) : '0;
    assign tx_early_v_o             = (state_q == ST_START);
    assign tx_pkt_len_o             = pkt_len_q;
    assign tx_cancel_o              = cancel_hit;
    assign tx_data_o                = in_stream ? sel_data : '0;
    assign tx_len_o                 = in_stream ? sel_len : '0;
    assign tx_last_o                = in_stream && sel_last;
    assign tx_last_block_next_o     = in_stream && sel_lbn;
    assign tx_last_block_next_len_o = in_stream ? sel_lbn_len : '0;

endmodule

// File: tb/tb_eth_tx_sched.sv
// tb/tb_eth_tx_sched.sv - directed self-checking bench for eth_tx_sched
module tb_eth_tx_sched;

    localparam int REQ_N  = 2;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 2;
    localparam int PLW    = 16;
    localparam int ALLW   = 4;

    logic                    clk;
    logic                    nreset;
    logic [REQ_N-1:0]        req_v_i;
    logic [REQ_N*PLW-1:0]    req_pkt_len_i;
    logic [REQ_N-1:0]        req_cancel_i;
    logic [REQ_N*DATA_W-1:0] req_data_i;
    logic [REQ_N*LEN_W-1:0]  req_len_i;
    logic [REQ_N-1:0]        req_last_i;
    logic [REQ_N-1:0]        req_last_block_next_i;
    logic [REQ_N*ALLW-1:0]   req_last_block_next_len_i;
    logic [REQ_N-1:0]        grant_o;
    logic [REQ_N-1:0]        req_ready_o;
    logic                    tx_early_v_o;
    logic [PLW-1:0]          tx_pkt_len_o;
    logic                    tx_cancel_o;
    logic                    tx_ready_v_i;
    logic [DATA_W-1:0]       tx_data_o;
    logic [LEN_W-1:0]        tx_len_o;
    logic                    tx_last_o;
    logic                    tx_last_block_next_o;
    logic [ALLW-1:0]         tx_last_block_next_len_o;
    logic                    tx_idle_i;

    int checks = 0;
    int errors = 0;

    eth_tx_sched #(
        .REQ_N(REQ_N), .DATA_W(DATA_W), .KEEP_W(2), .LEN_W(LEN_W), .PKT_LEN_W(PLW),
        .APP_LAST_LEN_W(ALLW), .IFG_N(12), .GAP_CYC(6)
    ) dut (
        .clk                       (clk),
        .nreset                    (nreset),
        .req_v_i                   (req_v_i),
        .req_pkt_len_i             (req_pkt_len_i),
        .req_cancel_i              (req_cancel_i),
        .req_data_i                (req_data_i),
        .req_len_i                 (req_len_i),
        .req_last_i                (req_last_i),
        .req_last_block_next_i     (req_last_block_next_i),
        .req_last_block_next_len_i (req_last_block_next_len_i),
        .grant_o                   (grant_o),
        .req_ready_o               (req_ready_o),
        .tx_early_v_o              (tx_early_v_o),
        .tx_pkt_len_o              (tx_pkt_len_o),
        .tx_cancel_o               (tx_cancel_o),
        .tx_ready_v_i              (tx_ready_v_i),
        .tx_data_o                 (tx_data_o),
        .tx_len_o                  (tx_len_o),
        .tx_last_o                 (tx_last_o),
        .tx_last_block_next_o      (tx_last_block_next_o),
        .tx_last_block_next_len_o  (tx_last_block_next_len_o),
        .tx_idle_i                 (tx_idle_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stream();
        req_data_i                = '0;
        req_len_i                 = '0;
        req_last_i                = '0;
        req_last_block_next_i     = '0;
        req_last_block_next_len_i = '0;
    endtask

    task automatic wait_start(input int r, input int plen, input string tag);
        int n;
        n = 0;
        while (!tx_early_v_o && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_early"}, 32'(tx_early_v_o), 32'd1);
        check({tag, "_grant"}, 32'(grant_o), 32'(1 << r));
        check({tag, "_pktlen"}, 32'(tx_pkt_len_o), 32'(plen));
    endtask

    task automatic count_to_start(output int n);
        n = 0;
        while (!tx_early_v_o && n < 40) begin
            tick();
            n++;
        end
    endtask

    // entered in START; leaves in DRAIN, or in GAP when cancel_beat is hit
    task automatic stream(input int r, input int nbeats, input int cancel_beat, input bit foreign_cancel);
        logic [15:0] exp_data;
        tick();
        for (int b = 0; b < nbeats; b++) begin
            clear_stream();
            exp_data = 16'((r << 12) | (b * 16 + 3));
            req_data_i[r*DATA_W +: DATA_W] = exp_data;
            req_len_i[r*LEN_W +: LEN_W]    = (b == nbeats-1) ? 2'd1 : 2'd2;
            req_last_i[r]                  = (b == nbeats-1);
            req_last_block_next_i[r]       = (b == nbeats-2);
            if (foreign_cancel) req_cancel_i[1-r] = 1'b1;
            if (b == 2) begin
                tx_ready_v_i = 1'b0;
                #1;
                check("stall_ready", 32'(req_ready_o), 32'd0);
                tick();
            end
            tx_ready_v_i = 1'b1;
            if (b == cancel_beat) req_cancel_i[r] = 1'b1;
            #1;
            check("beat_data", 32'(tx_data_o), 32'(exp_data));
            check("beat_ready", 32'(req_ready_o), 32'(1 << r));
            check("beat_last", 32'(tx_last_o), 32'(b == nbeats-1));
            check("beat_cancel", 32'(tx_cancel_o), 32'(b == cancel_beat));
            tick();
            req_cancel_i = '0;
            if (b == cancel_beat) break;
        end
        clear_stream();
        req_cancel_i = '0;
    endtask

    task automatic finish_frame();
        tick();
        repeat (6) tick();
    endtask

    initial begin
        int n;
        nreset                = 1'b0;
        req_v_i               = '0;
        req_pkt_len_i         = '0;
        req_cancel_i          = '0;
        tx_ready_v_i          = 1'b1;
        tx_idle_i             = 1'b1;
        clear_stream();
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_early", 32'(tx_early_v_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);
        check("rst_pktlen", 32'(tx_pkt_len_o), 32'd0);
        check("rst_cancel", 32'(tx_cancel_o), 32'd0);
        nreset = 1'b1;
        tick();

        // both requesting: strict alternation from pointer 0
        req_pkt_len_i = {16'd200, 16'd100};
        req_v_i       = 2'b11;
        for (int f = 0; f < 4; f++) begin
            wait_start(f % 2, (f % 2) ? 200 : 100, "rr");
            if (f == 3) req_v_i = '0;
            stream(f % 2, 3, -1, 1'b0);
        end
        finish_frame();
        check("rr_idle_grant", 32'(grant_o), 32'd0);

        // single requester 0: early pulse exactly one cycle after request
        req_pkt_len_i[15:0] = 16'd20;
        req_v_i             = 2'b01;
        #1;
        check("t1_idle_grant", 32'(grant_o), 32'd0);
        tick();
        check("t1_early_n1", 32'(tx_early_v_o), 32'd1);
        check("t1_grant", 32'(grant_o), 32'd1);
        check("t1_pktlen", 32'(tx_pkt_len_o), 32'd20);
        req_v_i = '0;
        stream(0, 10, -1, 1'b0);
        tx_idle_i = 1'b0;
        tick();
        check("drain_grant", 32'(grant_o), 32'd1);
        check("drain_data", 32'(tx_data_o), 32'd0);
        check("drain_ready", 32'(req_ready_o), 32'd0);
        tick();
        check("drain_grant2", 32'(grant_o), 32'd1);
        // back-to-back request from 0 arrives during DRAIN
        req_v_i             = 2'b01;
        req_pkt_len_i[15:0] = 16'd8;
        tx_idle_i           = 1'b1;
        tick();
        check("gap_grant", 32'(grant_o), 32'd0);
        check("gap_pktlen_hold", 32'(tx_pkt_len_o), 32'd20);
        count_to_start(n);
        check("gap_b2b_cycles", 32'(n), 32'd7);
        check("b2b_grant", 32'(grant_o), 32'd1);
        check("b2b_pktlen", 32'(tx_pkt_len_o), 32'd8);
        req_v_i = '0;
        stream(0, 2, -1, 1'b0);
        finish_frame();

        // requester 1 cancels on its third beat while requester 0 waits
        req_pkt_len_i[31:16] = 16'd300;
        req_v_i              = 2'b10;
        wait_start(1, 300, "cx");
        req_pkt_len_i[15:0] = 16'd40;
        req_v_i             = 2'b01;
        stream(1, 6, 2, 1'b0);
        check("cx_gap_grant", 32'(grant_o), 32'd0);
        count_to_start(n);
        check("cx_gap_cycles", 32'(n), 32'd7);
        check("cx_next_grant", 32'(grant_o), 32'd1);
        check("cx_next_pktlen", 32'(tx_pkt_len_o), 32'd40);
        req_v_i = '0;
        stream(0, 2, -1, 1'b0);
        finish_frame();

        // cancel from the non-owner must be ignored
        req_v_i = 2'b10;
        wait_start(1, 300, "fc");
        req_v_i = '0;
        stream(1, 4, -1, 1'b1);
        check("fc_drain_grant", 32'(grant_o), 32'd2);
        check("fc_drain_cancel", 32'(tx_cancel_o), 32'd0);
        finish_frame();

        // frame from 0 leaves the pointer at 1
        req_v_i = 2'b01;
        wait_start(0, 40, "p1");
        req_v_i = '0;
        stream(0, 2, -1, 1'b0);
        finish_frame();

        // reset in the middle of requester 1's data phase
        req_v_i = 2'b10;
        wait_start(1, 300, "rs");
        req_v_i = '0;
        tick();
        req_data_i[31:16] = 16'h5a5a;
        req_len_i[3:2]    = 2'd2;
        tx_ready_v_i      = 1'b1;
        #1;
        check("rs_data_live", 32'(tx_data_o), 32'h5a5a);
        tick();
        nreset = 1'b0;
        tick();
        check("rs_grant", 32'(grant_o), 32'd0);
        check("rs_data", 32'(tx_data_o), 32'd0);
        check("rs_len", 32'(tx_len_o), 32'd0);
        check("rs_ready", 32'(req_ready_o), 32'd0);
        check("rs_early", 32'(tx_early_v_o), 32'd0);
        check("rs_ptr", 32'(dut.rr_ptr), 32'd0);
        nreset = 1'b1;
        clear_stream();
        req_v_i = 2'b11;
        wait_start(0, 40, "rs_rr");
        req_v_i = '0;
        stream(0, 2, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
